// File: rtl/haahalia_pkg.sv
// Shared types and output bit map for the bit-serial subtractor tile.
package haahalia_pkg;

  localparam int unsigned WIDTH = 4;

  localparam int unsigned D_LSB      = 0;
  localparam int unsigned BORROW_BIT = 4;
  localparam int unsigned BUSY_BIT   = 5;
  localparam int unsigned DONE_BIT   = 6;
  localparam int unsigned OVF_BIT    = 7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/haahalia_half_sub.sv
// Half-subtractor cell: diff = a - b, borrow when b exceeds a.
module haahalia_half_sub (
  input  logic a_i,
  input  logic b_i,
  output logic diff_o,
  output logic borrow_o
);

  assign diff_o   = a_i ^ b_i;
  assign borrow_o = ~a_i & b_i;

endmodule

// File: rtl/tt_um_haahalia_serial_sub.sv
// Bit-serial 4-bit subtractor, LSB-first, one bit per enabled clock.
// Optional signed overflow flag on uo_out[7] when SUB_SIGNED_OVF_EN is defined.
module tt_um_haahalia_serial_sub
  import haahalia_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic             start_q;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, d_sr_q, d_sr_d, d_q, d_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             bflop_q, bflop_d, borrow_q, borrow_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             accept, complete, ovf;
  logic             diff1, bor1, step_diff, bor2, step_borrow;
  logic             unused_uio;

  assign unused_uio = ^uio_in[7:1];

  assign accept   = ena && (state_q == IDLE) && uio_in[0] && !start_q;
  assign complete = ena && (state_q == RUN) && (count_q == CntW'(WIDTH - 1));

  // Full-subtract step: (a0 - b0) then minus the stored borrow.
  haahalia_half_sub u_hs_ab (
    .a_i      (a_sr_q[0]),
    .b_i      (b_sr_q[0]),
    .diff_o   (diff1),
    .borrow_o (bor1)
  );

  haahalia_half_sub u_hs_bin (
    .a_i      (diff1),
    .b_i      (bflop_q),
    .diff_o   (step_diff),
    .borrow_o (bor2)
  );

  assign step_borrow = bor1 | bor2;

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    d_d      = d_q;
    count_d  = count_q;
    bflop_d  = bflop_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = done_q;
    if (accept) begin
      state_d = RUN;
      a_sr_d  = ui_in[3:0];
      b_sr_d  = ui_in[7:4];
      count_d = '0;
      bflop_d = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if (ena && state_q == RUN) begin
      bflop_d = step_borrow;
      a_sr_d  = a_sr_q >> 1;
      b_sr_d  = b_sr_q >> 1;
      d_sr_d  = {step_diff, d_sr_q[WIDTH-1:1]};
      count_d = count_q + CntW'(1);
      if (complete) begin
        d_d      = d_sr_d;
        borrow_d = step_borrow;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      d_q      <= '0;
      count_q  <= '0;
      bflop_q  <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      start_q  <= uio_in[0];
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      d_q      <= d_d;
      count_q  <= count_d;
      bflop_q  <= bflop_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  // Operand signs are kept aside since the shift registers lose them during RUN.
  logic a_sign_q, a_sign_d, b_sign_q, b_sign_d, ovf_q, ovf_d;

  always_comb begin
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_sign_d = ui_in[3];
      b_sign_d = ui_in[7];
    end
    if (complete) begin
      ovf_d = (a_sign_q != b_sign_q) && (step_diff != a_sign_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    uo_out                    = '0;
    uo_out[D_LSB +: WIDTH]    = d_q;
    uo_out[BORROW_BIT]        = borrow_q;
    uo_out[BUSY_BIT]          = busy_q;
    uo_out[DONE_BIT]          = done_q;
    uo_out[OVF_BIT]           = ovf;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_haahalia_serial_sub.sv
// Directed self-checking bench for the bit-serial subtractor tile.
module tb_tt_um_haahalia_serial_sub;

`ifdef SUB_SIGNED_OVF_EN
  localparam logic OvfOn = 1'b1;
`else
  localparam logic OvfOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests = 0;
  int n_fail  = 0;

  tt_um_haahalia_serial_sub dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_out(input logic [3:0] d, input logic bor, input logic busy,
                                         input logic done, input logic ovf);
    return {ovf & OvfOn, done, busy, bor, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then run the 4 serial steps and check the result.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic bor, input logic ovf);
    ui_in  = {b, a};
    uio_in = 8'h01;
    tick();
    uio_in = 8'h00;
    check_eq({tag, "_busy"}, {7'd0, uo_out[5]}, 8'h01);
    repeat (3) tick();
    check_eq({tag, "_notdone"}, {7'd0, uo_out[6]}, 8'h00);
    tick();
    check_eq({tag, "_result"}, uo_out, exp_out(d, bor, 1'b0, 1'b1, ovf));
  endtask

  always @(negedge clk) begin
    check_eq("uio_out", uio_out, 8'h00);
    check_eq("uio_oe", uio_oe, 8'h00);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #1;
    check_eq("reset", uo_out, 8'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_eq("idle", uo_out, 8'h00);

    run_op("t1", 4'd7, 4'd2, 4'd5, 1'b0, 1'b0);
    tick();
    run_op("t2", 4'd3, 4'd9, 4'hA, 1'b1, 1'b1);
    tick();
    run_op("t3", 4'd8, 4'd1, 4'd7, 1'b0, 1'b1);
    tick();

    // T4: start held high for 10 edges must run exactly one operation.
    ui_in  = 8'h00;
    uio_in = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_eq($sformatf("t4_busy%0d", i), {7'd0, uo_out[5]}, (i <= 4) ? 8'h01 : 8'h00);
    end
    check_eq("t4_result", uo_out, exp_out(4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    uio_in = 8'h00;
    tick();

    // T5: operands changed and start re-pulsed while busy, then a 3-cycle stall.
    ui_in  = 8'h15;
    uio_in = 8'h01;
    tick();
    ui_in  = 8'hFF;
    uio_in = 8'h00;
    tick();
    uio_in = 8'h01;
    tick();
    uio_in = 8'h00;
    ena    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("t5_stall%0d", i), uo_out, exp_out(4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    ena = 1'b1;
    tick();
    check_eq("t5_late", uo_out, exp_out(4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    check_eq("t5_result", uo_out, exp_out(4'd4, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();

    // T6: reset two cycles into a run aborts it.
    ui_in  = 8'h36;
    uio_in = 8'h01;
    tick();
    uio_in = 8'h00;
    tick();
    tick();
    check_eq("t6_running", uo_out, exp_out(4'd4, 1'b0, 1'b1, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    check_eq("t6_abort", uo_out, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("t6", 4'd6, 4'd3, 4'd3, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
